// File: rtl/mii_rx_deframer.sv
// -----------------------------------------------------------------------------
// mii_rx_deframer
//
// Receive-side MII deframer running in the system clock domain. MII nibbles
// arrive already sampled into this domain, qualified by a one-cycle strobe per
// MII receive clock. The block strips the preamble and SFD, packs nibbles
// low-nibble-first into bytes, and checks the CRC-32 and length of the frame.
// It emits a byte stream with start/end/error flags to the frame buffer.
//
// Each completed byte is held back by one byte time. This lets the final byte
// carry o_eof and the frame verdict, which is only known once RX_DV drops.
//
// Ports
//   i_sys_clk    in   1   system clock, rising edge
//   i_nreset     in   1   asynchronous active-low reset
//   i_rx_stb     in   1   i_rx_dv / i_rx_er / i_rxd valid this cycle
//   i_rx_dv      in   1   MII RX_DV sample
//   i_rx_er      in   1   MII RX_ER sample
//   i_rxd        in   4   MII RXD nibble
//   o_data       out  8   frame byte (dest MAC first, FCS included)
//   o_valid      out  1   one-cycle pulse qualifying o_data/o_sof/o_eof/o_err
//   o_sof        out  1   first byte of frame
//   o_eof        out  1   last byte of frame
//   o_err        out  1   frame bad (meaningful with o_eof)
//   o_frame_cnt  out 16   frames ended with EOF, saturating
//   o_err_cnt    out 16   frames ended with EOF and error, saturating
// -----------------------------------------------------------------------------
module mii_rx_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        i_sys_clk,
  input  logic        i_nreset,
  input  logic        i_rx_stb,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  input  logic [3:0]  i_rxd,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_err,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int          LW         = $clog2(MAX_LEN + 2);
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  // Register value after a frame and its own FCS have been shifted through.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [3:0]  NIB_PRE    = 4'h5;
  localparam logic [3:0]  NIB_SFD    = 4'hD;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_t;

  // CRC-32, data bits fed LSB first into a shift-left register with the normal
  // polynomial. This register is the bit-reverse of the usual reflected form.
  function automatic logic [31:0] crc32_refl(input logic [31:0] c,
                                             input logic [7:0]  d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[31] ^ d[i]) ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    end
    return r;
  endfunction

  // Frame state
  state_t        state,    state_n;
  logic          phase,    phase_n;
  logic [3:0]    low_nib,  low_nib_n;
  logic [7:0]    held,     held_n;
  logic          held_vld, held_vld_n;
  logic          first,    first_n;
  logic [LW-1:0] len,      len_n;
  logic          err,      err_n;
  logic [31:0]   crc,      crc_n;

  // Registered output stage
  logic [7:0]    data_n;
  logic          valid_n, sof_n, eof_n, err_out_n;

  logic [7:0]    new_byte;
  assign new_byte = {i_rxd, low_nib};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_n    = state;
    phase_n    = phase;
    low_nib_n  = low_nib;
    held_n     = held;
    held_vld_n = held_vld;
    first_n    = first;
    len_n      = len;
    err_n      = err;
    crc_n      = crc;
    data_n     = o_data;
    valid_n    = 1'b0;
    sof_n      = 1'b0;
    eof_n      = 1'b0;
    err_out_n  = 1'b0;

    if (i_rx_stb) begin
      unique case (state)
        IDLE: begin
          if (i_rx_dv) state_n = (i_rxd == NIB_PRE) ? PRE : DROP;
        end

        PRE: begin
          if (!i_rx_dv) begin
            state_n = IDLE;
          end else if (i_rxd == NIB_SFD) begin
            state_n    = DATA;
            phase_n    = 1'b0;
            len_n      = '0;
            err_n      = 1'b0;
            crc_n      = CRC_INIT;
            first_n    = 1'b1;
            held_vld_n = 1'b0;
          end else if (i_rxd != NIB_PRE) begin
            state_n = DROP;
          end
        end

        DATA: begin
          if (i_rx_dv) begin
            if (i_rx_er) err_n = 1'b1;
            if (!phase) begin
              low_nib_n = i_rxd;
              phase_n   = 1'b1;
            end else begin
              phase_n = 1'b0;
              if (len == LW'(MAX_LEN)) begin
                // Oversize: close the frame on the held byte and drop the rest.
                valid_n    = 1'b1;
                data_n     = held;
                sof_n      = first;
                eof_n      = 1'b1;
                err_out_n  = 1'b1;
                held_vld_n = 1'b0;
                state_n    = DROP;
              end else begin
                crc_n = crc32_refl(crc, new_byte);
                len_n = len + 1'b1;
                if (held_vld) begin
                  valid_n = 1'b1;
                  data_n  = held;
                  sof_n   = first;
                  first_n = 1'b0;
                end
                held_n     = new_byte;
                held_vld_n = 1'b1;
              end
            end
          end else begin
            // End of carrier: the held byte is the last byte of the frame.
            if (held_vld) begin
              valid_n   = 1'b1;
              data_n    = held;
              sof_n     = first;
              eof_n     = 1'b1;
              err_out_n = err | phase | (crc != CRC_RESIDUE) |
                          (len < LW'(MIN_LEN));
            end
            held_vld_n = 1'b0;
            state_n    = IDLE;
          end
        end

        DROP: begin
          if (!i_rx_dv) state_n = IDLE;
        end

        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_sys_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state    <= IDLE;
      phase    <= 1'b0;
      low_nib  <= '0;
      held     <= '0;
      held_vld <= 1'b0;
      first    <= 1'b0;
      len      <= '0;
      err      <= 1'b0;
      crc      <= CRC_INIT;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_sof    <= 1'b0;
      o_eof    <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      low_nib  <= low_nib_n;
      held     <= held_n;
      held_vld <= held_vld_n;
      first    <= first_n;
      len      <= len_n;
      err      <= err_n;
      crc      <= crc_n;
      o_data   <= data_n;
      o_valid  <= valid_n;
      o_sof    <= sof_n;
      o_eof    <= eof_n;
      o_err    <= err_out_n;
    end
  end

  // Frame statistics, counted off the registered output stream.
  always_ff @(posedge i_sys_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else if (o_valid && o_eof) begin
      if (o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (o_err && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_mii_rx_deframer
//
// Directed bench for mii_rx_deframer. A table of frame recipes, each with its
// expected byte count, error verdict and counter deltas, is applied in a loop.
// Reset behaviour and mid-frame reset are checked as hand-written sequences.
// The FCS is generated with the conventional reflected CRC-32 (poly EDB88320,
// final inversion), independent of the receiver's register form.
// -----------------------------------------------------------------------------
module tb_mii_rx_deframer;

  logic        clk = 1'b0;
  logic        nreset;
  logic        rx_stb, rx_dv, rx_er;
  logic [3:0]  rxd;
  logic [7:0]  data;
  logic        valid, sof, eof, err;
  logic [15:0] frame_cnt, err_cnt;

  always #5 clk = ~clk;

  mii_rx_deframer dut (
    .i_sys_clk   (clk),
    .i_nreset    (nreset),
    .i_rx_stb    (rx_stb),
    .i_rx_dv     (rx_dv),
    .i_rx_er     (rx_er),
    .i_rxd       (rxd),
    .o_data      (data),
    .o_valid     (valid),
    .o_sof       (sof),
    .o_eof       (eof),
    .o_err       (err),
    .o_frame_cnt (frame_cnt),
    .o_err_cnt   (err_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
  } cap_t;

  cap_t cap_q[$];
  int   stray = 0;   // flags without o_valid, or back-to-back o_valid
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (valid) cap_q.push_back('{data, sof, eof, err});
    if (!valid && (sof || eof || err)) stray++;
    if (valid && prev_valid) stray++;
    prev_valid = valid;
  end

  // ---------------- frame construction ----------------
  logic [7:0] frm [0:1599];
  int         frm_len;

  task automatic build_frame(input int len, input bit with_fcs, input int seed);
    logic [31:0] c;
    int          nd;
    nd = with_fcs ? len - 4 : len;
    for (int i = 0; i < nd; i++) frm[i] = 8'((i * 7 + seed * 13 + 1) & 255);
    if (with_fcs) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < nd; i++) begin
        c = c ^ {24'h0, frm[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) frm[nd + k] = c[8*k +: 8];
    end
    frm_len = len;
  endtask

  // One MII nibble every 4 system clocks; junk on the lines while stb=0.
  task automatic nib(input bit dv, input bit er, input logic [3:0] d);
    @(negedge clk);
    rx_stb = 1'b1; rx_dv = dv; rx_er = er; rxd = d;
    @(negedge clk);
    rx_stb = 1'b0; rx_dv = ~dv; rx_er = 1'b1; rxd = ~d;
    repeat (2) @(negedge clk);
  endtask

  // Preamble (optionally broken), SFD, frm[0..nbytes-1], optional extra nibble.
  task automatic send_body(input bit bad_pre, input int nbytes, input bit extra,
                           input int er_at);
    for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, (bad_pre && i == 3) ? 4'h3 : 4'h5);
    nib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < nbytes; i++) begin
      nib(1'b1, (2*i == er_at),   frm[i][3:0]);
      nib(1'b1, (2*i+1 == er_at), frm[i][7:4]);
    end
    if (extra) nib(1'b1, 1'b0, 4'h6);
  endtask

  task automatic end_frame();
    nib(1'b0, 1'b0, 4'h0);
    repeat (3) nib(1'b0, 1'b0, 4'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    int    len;       // bytes sent after SFD (FCS included when fcs=1)
    bit    fcs;
    bit    bad_fcs;   // XOR 01 into the last FCS byte
    bit    extra;     // one trailing nibble
    int    er_at;     // DATA nibble index with RX_ER, -1 none
    bit    bad_pre;
    int    exp_n;
    bit    exp_err;
    int    exp_fc;
    int    exp_ec;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"good64",    64,   1, 0, 0, -1, 0, 64,   0, 1, 0};
    vecs[1] = '{"badfcs",    64,   1, 1, 0, -1, 0, 64,   1, 1, 1};
    vecs[2] = '{"oddnib",    64,   1, 0, 1, -1, 0, 64,   1, 1, 1};
    vecs[3] = '{"rxer",      64,   1, 0, 0, 10, 0, 64,   1, 1, 1};
    vecs[4] = '{"runt20",    20,   1, 0, 0, -1, 0, 20,   1, 1, 1};
    vecs[5] = '{"giant1600", 1600, 1, 0, 0, -1, 0, 1518, 1, 1, 1};
    vecs[6] = '{"after_big", 100,  1, 0, 0, -1, 0, 100,  0, 1, 0};
    vecs[7] = '{"badpre",    64,   1, 0, 0, -1, 1, 0,    0, 0, 0};
    vecs[8] = '{"onebyte",   1,    0, 0, 0, -1, 0, 1,    1, 1, 1};
    vecs[9] = '{"sfd_drop",  0,    0, 0, 0, -1, 0, 0,    0, 0, 0};
  end

  task automatic run_vec(input vec_t v, input int seed);
    int base, n, sof_cnt, eof_cnt, bad_data, err_mid;
    int fc0, ec0;
    cap_t c;
    fc0 = frame_cnt; ec0 = err_cnt;
    base = cap_q.size();
    build_frame(v.len, v.fcs, seed);
    if (v.bad_fcs) frm[v.len-1] = frm[v.len-1] ^ 8'h01;
    send_body(v.bad_pre, v.len, v.extra, v.er_at);
    end_frame();
    n = cap_q.size() - base;
    sof_cnt = 0; eof_cnt = 0; bad_data = 0; err_mid = 0;
    for (int i = 0; i < n; i++) begin
      c = cap_q[base + i];
      if (c.sof) sof_cnt++;
      if (c.eof) eof_cnt++;
      if (c.err && !c.eof) err_mid++;
      if (c.data != frm[i]) bad_data++;
    end
    check({v.name, ".bytes"},     n,        v.exp_n);
    check({v.name, ".sof_cnt"},   sof_cnt,  (v.exp_n > 0) ? 1 : 0);
    check({v.name, ".eof_cnt"},   eof_cnt,  (v.exp_n > 0) ? 1 : 0);
    check({v.name, ".data_bad"},  bad_data, 0);
    check({v.name, ".err_mid"},   err_mid,  0);
    if (n > 0 && n == v.exp_n) begin
      check({v.name, ".sof_first"}, int'(cap_q[base].sof),       1);
      check({v.name, ".eof_last"},  int'(cap_q[base+n-1].eof),   1);
      check({v.name, ".err"},       int'(cap_q[base+n-1].err),   int'(v.exp_err));
    end
    check({v.name, ".frame_cnt"}, int'(frame_cnt) - fc0, v.exp_fc);
    check({v.name, ".err_cnt"},   int'(err_cnt) - ec0,   v.exp_ec);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, eofs;
    nreset = 1'b0; rx_stb = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 4'h0;
    repeat (3) @(negedge clk);
    check("rst.valid",     int'(valid),     0);
    check("rst.data",      int'(data),      0);
    check("rst.sof",       int'(sof),       0);
    check("rst.eof",       int'(eof),       0);
    check("rst.err",       int'(err),       0);
    check("rst.frame_cnt", int'(frame_cnt), 0);
    check("rst.err_cnt",   int'(err_cnt),   0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset in the middle of DATA: no EOF, counters cleared, then clean frame.
    base = cap_q.size();
    build_frame(64, 1'b1, 42);
    send_body(1'b0, 30, 1'b0, -1);
    @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.frame_cnt", int'(frame_cnt), 0);
    check("midrst.err_cnt",   int'(err_cnt),   0);
    nreset = 1'b1;
    repeat (4) nib(1'b1, 1'b0, 4'h7);   // remainder of the dead frame's carrier
    end_frame();
    eofs = 0;
    for (int i = base; i < cap_q.size(); i++) if (cap_q[i].eof) eofs++;
    check("midrst.no_eof", eofs, 0);
    check("midrst.bytes",  cap_q.size() - base, 29);
    run_vec('{"post_rst", 64, 1, 0, 0, -1, 0, 64, 0, 1, 0}, 43);
    check("post_rst.frame_abs", int'(frame_cnt), 1);

    check("stray_flags", stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the whole run is well under this bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
